// File: rtl/uart_echo_checker.sv
// uart_echo_checker
//   Drives a run of NUM_CHARS characters into a UART transmitter, starting at
//   START_CHAR and advancing by one each time (0x7E wraps to 0x20). After each
//   byte it waits up to TIMEOUT_CYCLES for the echo to come back. The far end
//   is expected to swap the case of ASCII letters. Every mismatched or missing
//   reply bumps a saturating error counter. At the end of a run, done and pass
//   report the outcome.
//
// Ports
//   CLK_125MHZ_FPGA  clock; all state changes on its rising edge
//   rst              synchronous, active-high reset
//   start            one-cycle pulse; honoured only in IDLE or DONE
//   data_in[7:0]     byte to the UART transmitter
//   data_in_valid    transmit byte valid
//   data_in_ready    transmitter can accept a byte
//   data_out[7:0]    byte from the UART receiver
//   data_out_valid   received byte valid
//   data_out_ready   checker accepts the received byte (IDLE, WAIT, DONE)
//   busy             run in progress (SEND, WAIT, NEXT)
//   done             run completed; held until start or rst
//   pass             completed run had zero errors
//   err_count[7:0]   mismatches plus timeouts, saturating at 255
//   state_dbg[2:0]   current FSM state (IDLE=0 SEND=1 WAIT=2 NEXT=3 DONE=4)
//
// Handshakes: a byte moves on a rising edge where valid and ready are both
// high. A source holds valid and data stable until that edge. The checker
// never drops data_in_valid or changes data_in before the transfer.
module uart_echo_checker #(
  parameter int unsigned NUM_CHARS      = 64,
  parameter logic [7:0]  START_CHAR     = 8'h20,
  parameter int unsigned TIMEOUT_CYCLES = 125_000
) (
  input  logic       CLK_125MHZ_FPGA,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] data_in,
  output logic       data_in_valid,
  input  logic       data_in_ready,
  input  logic [7:0] data_out,
  input  logic       data_out_valid,
  output logic       data_out_ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [2:0] state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    NUM_B      = 8'(NUM_CHARS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    sent_count;
  logic [7:0]    cur_char;

  assign state_dbg = state;

  // The reply the far end should produce for character c.
  function automatic logic [7:0] swap_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A)      swap_case = c + 8'h20;
    else if (c >= 8'h61 && c <= 8'h7A) swap_case = c - 8'h20;
    else                               swap_case = c;
  endfunction

  // Stay inside the printable range: after '~' go back to space.
  function automatic logic [7:0] advance(input logic [7:0] c);
    advance = (c == 8'h7E) ? 8'h20 : c + 8'h01;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (rst) begin
      state          <= S_IDLE;
      data_in        <= 8'h00;
      data_in_valid  <= 1'b0;
      data_out_ready <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 8'h00;
      timer          <= '0;
      sent_count     <= 8'h00;
      cur_char       <= START_CHAR;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Bytes offered here are accepted and dropped (data_out_ready=1).
          if (start) begin
            err_count      <= 8'h00;
            sent_count     <= 8'h00;
            cur_char       <= START_CHAR;
            done           <= 1'b0;
            pass           <= 1'b0;
            data_in        <= START_CHAR;
            data_in_valid  <= 1'b1;
            data_out_ready <= 1'b0;
            busy           <= 1'b1;
            state          <= S_SEND;
          end
        end
        S_SEND: begin
          if (data_in_valid && data_in_ready) begin
            data_in_valid  <= 1'b0;
            data_out_ready <= 1'b1;
            timer          <= '0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A reply wins over a timeout that lands on the same cycle.
          if (data_out_valid) begin
            if (data_out != swap_case(cur_char)) err_count <= sat_inc(err_count);
            data_out_ready <= 1'b0;
            state          <= S_NEXT;
          end else if (timer == TIMER_LAST) begin
            err_count      <= sat_inc(err_count);
            data_out_ready <= 1'b0;
            state          <= S_NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_NEXT: begin
          sent_count <= sent_count + 8'd1;
          if (sent_count + 8'd1 == NUM_B) begin
            done           <= 1'b1;
            pass           <= (err_count == 8'h00);
            busy           <= 1'b0;
            data_out_ready <= 1'b1;
            state          <= S_DONE;
          end else begin
            cur_char      <= advance(cur_char);
            data_in       <= advance(cur_char);
            data_in_valid <= 1'b1;
            state         <= S_SEND;
          end
        end
        default: begin
          state          <= S_IDLE;
          data_in_valid  <= 1'b0;
          data_out_ready <= 1'b1;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_echo_checker.md
UART_ECHO_CHECKER -- requirements
Module: uart_echo_checker

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 64, number of characters sent per test run (1..255).
REQ-002 SHALL have parameter START_CHAR, default 8'h20, first character sent.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 125_000, number of clock cycles to wait for each reply.
REQ-004 SHALL have port CLK_125MHZ_FPGA  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a test run.
REQ-007 SHALL have port data_in  output  8  byte to the UART transmitter.
REQ-008 SHALL have port data_in_valid  output  1  transmit byte valid.
REQ-009 SHALL have port data_in_ready  input  1  UART transmitter can accept a byte.
REQ-010 SHALL have port data_out  input  8  byte from the UART receiver.
REQ-011 SHALL have port data_out_valid  input  1  received byte valid.
REQ-012 SHALL have port data_out_ready  output  1  checker accepts the received byte.
REQ-013 SHALL have port busy  output  1  a test run is in progress.
REQ-014 SHALL have port done  output  1  a test run has completed.
REQ-015 SHALL have port pass  output  1  the completed run had zero errors.
REQ-016 SHALL have port err_count  output  8  mismatches plus timeouts, saturating at 255.

Function
REQ-017 SHALL implement the states IDLE, SEND, WAIT, NEXT and DONE, all registered.
REQ-018 SHALL accept start only in IDLE or DONE; on start: err_count=0, sent count=0, cur_char=START_CHAR, done=0, pass=0, then go to SEND; start in any other state is ignored.
REQ-019 SHALL in SEND drive data_in=cur_char and data_in_valid=1, holding both stable until a cycle in which data_in_valid and data_in_ready are both high.
REQ-020 SHALL on that SEND handshake go to WAIT the next cycle, clear the timeout timer, and drop data_in_valid.
REQ-021 SHALL drive data_out_ready=1 in IDLE, WAIT and DONE, and 0 in SEND and NEXT; bytes accepted in IDLE or DONE are discarded.
REQ-022 SHALL compute expected = case-swapped cur_char: 0x41-0x5A add 0x20; 0x61-0x7A subtract 0x20; otherwise unchanged.
REQ-023 SHALL in WAIT, when data_out_valid=1, compare data_out with expected, increment err_count (saturating at 255) on mismatch, and go to NEXT.
REQ-024 SHALL in WAIT, when the timer reaches TIMEOUT_CYCLES-1 with no byte received, increment err_count (saturating) and go to NEXT; a reply arriving in the same cycle as the timeout is treated as a reply, not a timeout.
REQ-025 SHALL in NEXT increment the sent count; if it equals NUM_CHARS go to DONE, else advance cur_char and go to SEND.
REQ-026 SHALL advance cur_char by +1, wrapping 0x7E to 0x20.
REQ-027 SHALL assert busy only in SEND, WAIT and NEXT.
REQ-028 SHALL in DONE hold done=1 and pass=(err_count==0) until start or rst.
REQ-029 SHALL have a response time from a WAIT byte handshake to the next SEND data_in_valid of exactly 2 cycles.

Reset
REQ-030 SHALL on rst, in any state, go to IDLE with data_in_valid=0, data_in=0, busy=0, done=0, pass=0, err_count=0, timer=0, sent count=0.
REQ-031 SHALL discard a reply that arrives after rst was asserted in WAIT, accepting it in IDLE without counting it.

Verification
REQ-032 SHALL pass this scenario: case-swap echo model, START_CHAR=8'h41, NUM_CHARS=4 -> sends 41,42,43,44; receives 61,62,63,64; done=1, pass=1, err_count=0.
REQ-033 SHALL pass this scenario: echo model corrupts the 2nd reply to 8'h00 -> done=1, pass=0, err_count=1.
REQ-034 SHALL pass this scenario: no replies, TIMEOUT_CYCLES=100, NUM_CHARS=3 -> each WAIT lasts 100 cycles; err_count=3, pass=0.
REQ-035 SHALL pass this scenario: START_CHAR=8'h7D, NUM_CHARS=3 -> sends 7D,7E,20; replies unchanged; pass=1.
REQ-036 SHALL pass this scenario: data_in_ready held low 50 cycles in SEND -> data_in_valid=1 and data_in stable for all 50 cycles; exactly one byte is transferred.
REQ-037 SHALL pass this scenario: rst pulsed in WAIT, then a late reply -> state IDLE, all outputs at reset values, err_count stays 0, done=0.
